// File: rtl/nphy_output_serializer.sv
// NAND PHY output serializer: buffers RATIO-slot parallel words in a small FIFO and
// shifts them out one slot per clock on LANES pins, with output enables aligned to the data.
module nphy_output_serializer #(
  parameter int               LANES       = 8,
  parameter int               RATIO       = 4,
  parameter int               DEPTH       = 4,
  parameter logic [LANES-1:0] IDLE_VALUE  = '0,
  parameter logic [LANES-1:0] INVERT_MASK = '0
) (
  input  logic                       iSystemClock,
  input  logic                       iModuleReset,
  input  logic [LANES*RATIO-1:0]     iData,
  input  logic                       iOutEnable,
  input  logic                       iValid,
  output logic                       oReady,
  input  logic                       iFlush,
  input  logic                       iBurstActive,
  input  logic                       iClearStatus,
  output logic [LANES-1:0]           oSerial,
  output logic [LANES-1:0]           oOutEnable,
  output logic [$clog2(DEPTH):0]     oLevel,
  output logic                       oBusy,
  output logic                       oUnderrun
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int CNT_W  = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int WORD_W = LANES * RATIO;
  localparam logic [LANES-1:0] IDLE_PIN = IDLE_VALUE ^ INVERT_MASK;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  logic [WORD_W:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [LANES-1:0]   serial_q, serial_d, oe_q, oe_d;
  logic               und_q, und_d, und_set;
  logic               push, pop;
  logic [WORD_W:0]    head;

  function automatic logic [LANES-1:0] slot_of(input logic [WORD_W-1:0] w,
                                               input logic [CNT_W-1:0]  s);
    return w[int'(s)*LANES +: LANES];
  endfunction

  // Reset gating keeps the input side closed while the block is held in reset.
  assign oReady = iModuleReset & (level_q < LVL_W'(DEPTH)) & ~iFlush;
  assign push   = iValid & oReady;
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    serial_d = serial_q;
    oe_d     = oe_q;
    pop      = 1'b0;
    und_set  = 1'b0;
    if (iFlush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      serial_d = IDLE_PIN;
      oe_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (level_q != '0) pop = 1'b1;
        end
        ST_SHIFT: begin
          if (cnt_q == CNT_W'(RATIO - 1)) begin
            if (level_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              cnt_d    = '0;
              serial_d = IDLE_PIN;
              oe_d     = '0;
              und_set  = iBurstActive;
            end
          end else begin
            cnt_d    = cnt_q + 1'b1;
            serial_d = slot_of(word_q, cnt_q + 1'b1) ^ INVERT_MASK;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // Loading drives slot 0 on the same edge, so consecutive words abut.
      if (pop) begin
        state_d  = ST_SHIFT;
        cnt_d    = '0;
        word_d   = head[WORD_W-1:0];
        serial_d = head[LANES-1:0] ^ INVERT_MASK;
        oe_d     = {LANES{head[WORD_W]}};
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    und_d    = und_set | (und_q & ~iClearStatus);
    if (iFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge iSystemClock or negedge iModuleReset) begin
    if (!iModuleReset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      serial_q <= IDLE_PIN;
      oe_q     <= '0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      serial_q <= serial_d;
      oe_q     <= oe_d;
      und_q    <= und_d;
    end
  end

  always_ff @(posedge iSystemClock) begin
    word_q <= word_d;
    if (push) mem_q[wr_ptr_q] <= {iOutEnable, iData};
  end

  assign oSerial    = serial_q;
  assign oOutEnable = oe_q;
  assign oLevel     = level_q;
  assign oBusy      = (state_q == ST_SHIFT) | (level_q != '0);
  assign oUnderrun  = und_q;

endmodule

// File: tb/tb_nphy_output_serializer.sv
// Bench for nphy_output_serializer: directed scenarios plus random traffic, checked every
// cycle against a word-schedule reference model (default instance and an inverted-pin instance).
`timescale 1ns/1ps
module tb_nphy_output_serializer;
  localparam int LANES = 8, RATIO = 4, DEPTH = 4, W = LANES * RATIO;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] iData = '0;
  logic         iOE = 1'b0, iValid = 1'b0, iFlush = 1'b0, iBurst = 1'b0, iClr = 1'b0;

  logic         a_rdy, a_busy, a_und, b_rdy, b_busy, b_und;
  logic [7:0]   a_ser, a_oe, b_ser, b_oe;
  logic [2:0]   a_lvl, b_lvl;

  always #5 clk = ~clk;

  nphy_output_serializer u_dut (
    .iSystemClock(clk), .iModuleReset(rst_n), .iData(iData), .iOutEnable(iOE),
    .iValid(iValid), .oReady(a_rdy), .iFlush(iFlush), .iBurstActive(iBurst),
    .iClearStatus(iClr), .oSerial(a_ser), .oOutEnable(a_oe), .oLevel(a_lvl),
    .oBusy(a_busy), .oUnderrun(a_und));

  nphy_output_serializer #(.IDLE_VALUE(8'h01), .INVERT_MASK(8'h0F)) u_dut_inv (
    .iSystemClock(clk), .iModuleReset(rst_n), .iData(iData), .iOutEnable(iOE),
    .iValid(iValid), .oReady(b_rdy), .iFlush(iFlush), .iBurstActive(iBurst),
    .iClearStatus(iClr), .oSerial(b_ser), .oOutEnable(b_oe), .oLevel(b_lvl),
    .oBusy(b_busy), .oUnderrun(b_und));

  int n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted word is given the cycle range in which its slots are on the pins.
  typedef struct {
    int          push;
    int          start;
    int          stop;
    int          nend;
    logic [31:0] d;
    logic        oe;
  } ent_t;

  ent_t sched[$];
  int   last_end = -100;
  logic und_m = 1'b0;
  logic accepted;
  logic [7:0] obs_ser, obs_inv, obs_oe;
  logic [2:0] obs_lvl;
  logic obs_rdy, obs_busy, obs_und;

  function automatic int m_level(int t);
    int n = 0;
    foreach (sched[i]) if (sched[i].push < t && sched[i].start > t) n++;
    return n;
  endfunction

  function automatic int m_cover(int t);
    foreach (sched[i]) if (sched[i].start <= t && t <= sched[i].stop) return i;
    return -1;
  endfunction

  function automatic logic [7:0] slot8(logic [31:0] d, int s);
    return d[s*8 +: 8];
  endfunction

  task automatic model_reset();
    sched.delete();
    last_end = -100;
    und_m    = 1'b0;
  endtask

  task automatic run_cycle();
    int lvl, idx, st;
    logic [7:0] es, ei, eo;
    logic rdy, ended, has_next, set;
    ent_t e;
    @(negedge clk);
    lvl = m_level(cyc);
    idx = m_cover(cyc);
    es = 8'h00; ei = 8'h0E; eo = 8'h00;
    if (idx >= 0) begin
      es = slot8(sched[idx].d, cyc - sched[idx].start);
      ei = es ^ 8'h0F;
      eo = sched[idx].oe ? 8'hFF : 8'h00;
    end
    rdy = (lvl < DEPTH) && !iFlush;
    check_val("serial",     32'(a_ser),  32'(es));
    check_val("serial_inv", 32'(b_ser),  32'(ei));
    check_val("out_enable", 32'(a_oe),   32'(eo));
    check_val("level",      32'(a_lvl),  32'(lvl));
    check_val("busy",       32'(a_busy), 32'((idx >= 0) || (lvl != 0)));
    check_val("ready",      32'(a_rdy),  32'(rdy));
    check_val("underrun",   32'(a_und),  32'(und_m));
    obs_ser = a_ser; obs_inv = b_ser; obs_oe = a_oe; obs_lvl = a_lvl;
    obs_rdy = a_rdy; obs_busy = a_busy; obs_und = a_und;
    accepted = iValid && rdy;
    ended = 1'b0; has_next = 1'b0;
    foreach (sched[i]) begin
      if (sched[i].start == cyc + 1) has_next = 1'b1;
      if (sched[i].stop == sched[i].nend && sched[i].nend == cyc) ended = 1'b1;
    end
    set   = ended && !has_next && iBurst && !iFlush;
    und_m = set || (und_m && !iClr);
    if (iFlush) begin
      for (int i = sched.size() - 1; i >= 0; i--) begin
        if (sched[i].start > cyc) sched.delete(i);
        else if (sched[i].stop > cyc) sched[i].stop = cyc;
      end
      last_end = cyc;
    end
    if (accepted) begin
      st = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
      e.push = cyc; e.start = st; e.stop = st + RATIO - 1; e.nend = st + RATIO - 1;
      e.d = iData; e.oe = iOE;
      sched.push_back(e);
      last_end = st + RATIO - 1;
    end
    while (sched.size() > 0 && sched[0].stop < cyc) void'(sched.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_word(input logic [31:0] d, input logic oe);
    iValid = 1'b1; iData = d; iOE = oe;
    accepted = 1'b0;
    for (int k = 0; k < 20 && !accepted; k++) run_cycle();
    if (!accepted) check_val("push_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic reset_checks(input string tag);
    check_val({tag, "_ready"},  32'(a_rdy),  32'd0);
    check_val({tag, "_serial"}, 32'(a_ser),  32'h00);
    check_val({tag, "_inv"},    32'(b_ser),  32'h0E);
    check_val({tag, "_oe"},     32'(a_oe),   32'h00);
    check_val({tag, "_level"},  32'(a_lvl),  32'd0);
    check_val({tag, "_busy"},   32'(a_busy), 32'd0);
    check_val({tag, "_und"},    32'(a_und),  32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    reset_checks("rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // Single word A5,3C,FF,00 with OE
    push_word({8'h00, 8'hFF, 8'h3C, 8'hA5}, 1'b1);
    iValid = 1'b0;
    run_cycle();
    run_cycle(); check_val("t1_slot0", 32'(obs_ser), 32'hA5);
                 check_val("t1_oe",    32'(obs_oe),  32'hFF);
    run_cycle(); check_val("t1_slot1", 32'(obs_ser), 32'h3C);
    run_cycle(); check_val("t1_slot2", 32'(obs_ser), 32'hFF);
    run_cycle(); check_val("t1_slot3", 32'(obs_ser), 32'h00);
                 check_val("t1_inv_slot3", 32'(obs_inv), 32'h0F);
    run_cycle(); check_val("t1_idle",  32'(obs_ser), 32'h00);
                 check_val("t1_idle_oe", 32'(obs_oe), 32'h00);
                 check_val("t1_no_und",  32'(obs_und), 32'd0);

    // Six words streamed with valid held
    for (int k = 0; k < 6; k++) push_word($urandom, 1'(k % 2));
    iValid = 1'b0;
    repeat (28) run_cycle();

    // Underrun, clear, and set-beats-clear
    iBurst = 1'b1;
    push_word($urandom, 1'b1);
    iValid = 1'b0;
    repeat (5) run_cycle();
    run_cycle(); check_val("t4_und_set", 32'(obs_und), 32'd1);
    push_word($urandom, 1'b0);
    iValid = 1'b0;
    repeat (4) run_cycle();
    iClr = 1'b1;
    run_cycle();
    iClr = 1'b0;
    run_cycle(); check_val("t4_set_wins", 32'(obs_und), 32'd1);
    iBurst = 1'b0; iClr = 1'b1;
    run_cycle();
    iClr = 1'b0;
    run_cycle(); check_val("t4_cleared", 32'(obs_und), 32'd0);

    // Flush during slot 1 of the first of three queued words
    push_word($urandom, 1'b1);
    push_word($urandom, 1'b1);
    push_word($urandom, 1'b0);
    iData = $urandom; iValid = 1'b1; iFlush = 1'b1;
    run_cycle(); check_val("t5_rdy_in_flush", 32'(obs_rdy), 32'd0);
    iFlush = 1'b0; iValid = 1'b0;
    run_cycle(); check_val("t5_serial", 32'(obs_ser),  32'h00);
                 check_val("t5_oe",     32'(obs_oe),   32'h00);
                 check_val("t5_level",  32'(obs_lvl),  32'd0);
                 check_val("t5_busy",   32'(obs_busy), 32'd0);
    repeat (6) run_cycle();

    // Asynchronous reset in the middle of a word
    push_word(32'h11223344, 1'b1);
    iValid = 1'b0;
    run_cycle();
    run_cycle();
    #2 rst_n = 1'b0;
    #1 reset_checks("t6_rst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    run_cycle(); check_val("t6_ready", 32'(obs_rdy), 32'd1);
    push_word(32'h8899AABB, 1'b1);
    iValid = 1'b0;
    run_cycle();
    run_cycle(); check_val("t6_slot0", 32'(obs_ser), 32'hBB);
    repeat (4) run_cycle();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      iBurst = 1'($urandom_range(0, 1));
      iClr   = ($urandom_range(0, 7) == 0);
      iFlush = ($urandom_range(0, 29) == 0);
      if (!iValid && $urandom_range(0, 2) != 0) begin
        iValid = 1'b1; iData = $urandom; iOE = 1'($urandom_range(0, 1));
      end
      run_cycle();
      if (accepted) iValid = 1'b0;
    end
    iValid = 1'b0; iFlush = 1'b0; iClr = 1'b0; iBurst = 1'b0;
    repeat (24) run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
